mem_io_responder: RTL and testbench

Bus responder on the far side of the CPU's byte-wide memory port. It serves RAM reads and writes from an internal byte RAM, and decodes the memory-mapped I/O window (`mem_a[17:16]==2'b11`). The I/O window covers UART TX/RX byte FIFOs, a cycle counter and the program-stop port. It drives `io_buffer_full` back to the CPU and sits between the CPU top and the UART/host-interface shell.

---
 rtl/mem_io_responder_pkg.sv | 14 +
 rtl/mem_io_responder_byte_fifo.sv | 53 +++++
 rtl/mem_io_responder.sv | 130 +++++++++++++
 tb/tb_mem_io_responder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the CPU-side memory responder: I/O window select,
// I/O port offsets and the default byte-RAM address width.
package mem_io_responder_pkg;

  localparam logic [1:0] IO_BASE_SEL           = 2'b11;
  localparam logic [2:0] IO_PORT_UART          = 3'd0;
  localparam logic [2:0] IO_PORT_CLK           = 3'd4;
  localparam logic [2:0] IO_PORT_SNAP1         = 3'd5;
  localparam logic [2:0] IO_PORT_SNAP2         = 3'd6;
  localparam logic [2:0] IO_PORT_SNAP3         = 3'd7;
  localparam int         RAM_ADDR_BITS_DEFAULT = 17;
  localparam int         FIFO_DEPTH_BITS_DEFAULT = 4;

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Circular byte FIFO with wrap-around pointers and an explicit occupancy count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module byte_fifo #(
  parameter int DEPTH_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [7:0]          din,
  input  logic                pop,
  output logic [7:0]          dout,
  output logic                empty,
  output logic                full,
  output logic [DEPTH_BITS:0] count
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS + 1)'(DEPTH);

  logic [7:0]            storage [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic                  wr_en;
  logic                  rd_en;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || pop);
  // Head is 0x00 when empty, so a pop of an empty FIFO reads as zero.
  assign dout  = empty ? 8'h00 : storage[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) storage[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Far-side responder of the CPU byte memory port: byte RAM plus an I/O window
// with UART TX/RX FIFOs, a free-running cycle counter and the program-stop port.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_BITS   = RAM_ADDR_BITS_DEFAULT,
  parameter int FIFO_DEPTH_BITS = FIFO_DEPTH_BITS_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        program_finished,
  output logic        tx_overflow
);

  localparam int TX_DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [FIFO_DEPTH_BITS:0] NEAR_FULL = (FIFO_DEPTH_BITS + 1)'(TX_DEPTH - 2);

  logic [7:0] ram [2**RAM_ADDR_BITS];

  logic                     is_io;
  logic [2:0]               port;
  logic [RAM_ADDR_BITS-1:0] ram_addr;
  logic [31:0]              cycle_cnt;
  logic [31:8]              snap;

  logic                     tx_push, tx_pop, tx_empty, tx_full, tx_wr_ok;
  logic [7:0]               tx_din;
  logic [FIFO_DEPTH_BITS:0] tx_count, tx_count_nxt;
  logic                     rx_pop, rx_empty, rx_full;
  logic [7:0]               rx_dout;
  logic [FIFO_DEPTH_BITS:0] rx_count;
  logic                     unused_bits;

  assign is_io    = (mem_a[17:16] == IO_BASE_SEL);
  assign port     = mem_a[2:0];
  assign ram_addr = mem_a[RAM_ADDR_BITS-1:0];

  // TX handshake: a byte transfers on every rising edge where tx_valid and
  // tx_ready are both high; tx_data is stable while tx_valid waits for tx_ready.
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_push  = mem_wr && is_io &&
                    ((port == IO_PORT_UART && mem_dout != 8'h00) || port == IO_PORT_CLK);
  assign tx_din   = (port == IO_PORT_CLK) ? 8'h00 : mem_dout;
  assign tx_wr_ok = tx_push && (!tx_full || tx_pop);
  assign rx_pop   = !mem_wr && is_io && (port == IO_PORT_UART);

  always_comb begin
    tx_count_nxt = tx_count;
    case ({tx_wr_ok, tx_pop})
      2'b10:   tx_count_nxt = tx_count + 1'b1;
      2'b01:   tx_count_nxt = tx_count - 1'b1;
      default: tx_count_nxt = tx_count;
    endcase
  end

  byte_fifo #(.DEPTH_BITS(FIFO_DEPTH_BITS)) u_tx_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (tx_push),
    .din   (tx_din),
    .pop   (tx_pop),
    .dout  (tx_data),
    .empty (tx_empty),
    .full  (tx_full),
    .count (tx_count)
  );

  byte_fifo #(.DEPTH_BITS(FIFO_DEPTH_BITS)) u_rx_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (rx_valid),
    .din   (rx_data),
    .pop   (rx_pop),
    .dout  (rx_dout),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in && mem_wr && !is_io) ram[ram_addr] <= mem_dout;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_din          <= 8'h00;
      io_buffer_full   <= 1'b0;
      program_finished <= 1'b0;
      tx_overflow      <= 1'b0;
      cycle_cnt        <= '0;
      snap             <= '0;
    end else begin
      cycle_cnt      <= cycle_cnt + 1'b1;
      io_buffer_full <= (tx_count_nxt >= NEAR_FULL);
      if (tx_push && tx_full && !tx_pop) tx_overflow <= 1'b1;
      if (mem_wr && is_io && port == IO_PORT_CLK) program_finished <= 1'b1;
      if (!mem_wr) begin
        if (is_io) begin
          case (port)
            IO_PORT_UART:  mem_din <= rx_dout;
            IO_PORT_CLK: begin
              mem_din <= cycle_cnt[7:0];
              snap    <= cycle_cnt[31:8];
            end
            IO_PORT_SNAP1: mem_din <= snap[15:8];
            IO_PORT_SNAP2: mem_din <= snap[23:16];
            IO_PORT_SNAP3: mem_din <= snap[31:24];
            default:       mem_din <= 8'h00;
          endcase
        end else begin
          mem_din <= ram[ram_addr];
        end
      end
    end
  end

  assign unused_bits = ^{mem_a[31:18], rx_empty, rx_full, rx_count};

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: RAM, UART TX/RX FIFOs, cycle
// counter snapshot, program-stop port and reset behaviour.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        program_finished;
  logic        tx_overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_b;

  always #5 clk_in = ~clk_in;

  mem_io_responder dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .mem_a            (mem_a),
    .mem_wr           (mem_wr),
    .mem_dout         (mem_dout),
    .mem_din          (mem_din),
    .io_buffer_full   (io_buffer_full),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .program_finished (program_finished),
    .tx_overflow      (tx_overflow)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] data);
    mem_a = addr; mem_wr = 1'b1; mem_dout = data;
    step();
    mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
  endtask

  // Issues a read and leaves mem_din from that read visible after return.
  task automatic do_read(input logic [31:0] addr);
    mem_a = addr; mem_wr = 1'b0;
    step();
    mem_a = 32'h0;
  endtask

  task automatic drain_tx(input string name);
    int guard;
    guard = 0;
    tx_ready = 1'b1;
    while (tx_q.size() > 0 && guard < 40) begin
      if (tx_valid) begin
        exp_b = tx_q.pop_front();
        checks++;
        if (tx_data !== exp_b) begin
          errors++;
          $display("FAIL %s_data: got %h expected %h", name, tx_data, exp_b);
        end
      end
      step();
      guard++;
    end
    tx_ready = 1'b0;
    checks++;
    if (tx_q.size() != 0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: left %0d tx_valid %b expected 0 0", name, tx_q.size(), tx_valid);
    end
    tx_q.delete();
  endtask

  task automatic test_reset();
    rst_in = 1'b1; mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    step(); step();
    checks++;
    if ({mem_din, io_buffer_full, program_finished, tx_overflow, tx_valid, tx_data} !== 20'h0) begin
      errors++;
      $display("FAIL reset: got din %h bf %b pf %b ov %b tv %b td %h expected all 0",
               mem_din, io_buffer_full, program_finished, tx_overflow, tx_valid, tx_data);
    end
    rst_in = 1'b0;
  endtask

  task automatic test_ram();
    logic [31:0] addr;
    logic [7:0]  val [8];
    do_write(32'h0000_0124, 8'h3C);
    do_write(32'h0000_0123, 8'hA5);
    do_read(32'h0000_0123);
    exp_q.push_back(8'hA5);
    exp_b = exp_q.pop_front();
    checks++;
    if (mem_din !== exp_b) begin
      errors++; $display("FAIL ram_rd: got %h expected %h", mem_din, exp_b);
    end
    do_write(32'h0000_0200, 8'h11);
    checks++;
    if (mem_din !== 8'hA5) begin
      errors++; $display("FAIL ram_hold_on_write: got %h expected a5", mem_din);
    end
    do_read(32'h0000_0124);
    exp_q.push_back(8'h3C);
    exp_b = exp_q.pop_front();
    checks++;
    if (mem_din !== exp_b) begin
      errors++; $display("FAIL ram_unrelated: got %h expected %h", mem_din, exp_b);
    end
    for (int i = 0; i < 8; i++) begin
      val[i] = 8'($urandom_range(0, 255));
      addr = 32'h0001_0000 + 32'(i * 4099);
      do_write(addr, val[i]);
    end
    for (int i = 0; i < 8; i++) begin
      addr = 32'h0001_0000 + 32'(i * 4099);
      exp_q.push_back(val[i]);
      do_read(addr);
      exp_b = exp_q.pop_front();
      checks++;
      if (mem_din !== exp_b) begin
        errors++; $display("FAIL ram_rand%0d: got %h expected %h", i, mem_din, exp_b);
      end
    end
  endtask

  task automatic test_tx();
    tx_ready = 1'b0;
    do_write(32'h0003_0000, 8'h48); tx_q.push_back(8'h48);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin
      errors++; $display("FAIL tx_latency: got tv %b td %h expected 1 48", tx_valid, tx_data);
    end
    do_write(32'h0003_0000, 8'h00);
    do_write(32'h0003_0000, 8'h69); tx_q.push_back(8'h69);
    drain_tx("tx_zero_filter");
  endtask

  task automatic test_full();
    logic [7:0] b;
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom_range(1, 255));
      do_write(32'h0003_0000, b);
      if (i < 16) tx_q.push_back(b);
      if (i == 12) begin
        checks++;
        if (io_buffer_full !== 1'b0) begin
          errors++; $display("FAIL full_at13: got %b expected 0", io_buffer_full);
        end
      end
      if (i == 13) begin
        checks++;
        if (io_buffer_full !== 1'b1) begin
          errors++; $display("FAIL full_at14: got %b expected 1", io_buffer_full);
        end
      end
      if (i == 15) begin
        checks++;
        if (tx_overflow !== 1'b0) begin
          errors++; $display("FAIL ovf_at16: got %b expected 0", tx_overflow);
        end
      end
    end
    checks++;
    if (tx_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_at17: got %b expected 1", tx_overflow);
    end
    drain_tx("tx_full");
    checks++;
    if (io_buffer_full !== 1'b0 || tx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL full_after_drain: got bf %b ov %b expected 0 1", io_buffer_full, tx_overflow);
    end
  endtask

  task automatic test_rx();
    logic [7:0] b;
    rx_valid = 1'b1; rx_data = 8'h31; step();
    rx_data = 8'h32; step();
    rx_valid = 1'b0;
    exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h00);
    for (int i = 0; i < 3; i++) begin
      do_read(32'h0003_0000);
      exp_b = exp_q.pop_front();
      checks++;
      if (mem_din !== exp_b) begin
        errors++; $display("FAIL rx_basic%0d: got %h expected %h", i, mem_din, exp_b);
      end
    end
    // Overfill by one: the 17th byte is dropped.
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom_range(1, 255));
      rx_valid = 1'b1; rx_data = b; step();
      if (i < 16) exp_q.push_back(b);
    end
    rx_valid = 1'b0;
    exp_q.push_back(8'h00);
    for (int i = 0; i < 17; i++) begin
      do_read(32'h0003_0000);
      exp_b = exp_q.pop_front();
      checks++;
      if (mem_din !== exp_b) begin
        errors++; $display("FAIL rx_full%0d: got %h expected %h", i, mem_din, exp_b);
      end
    end
    // Simultaneous push and pop on an empty FIFO.
    rx_valid = 1'b1; rx_data = 8'h77;
    do_read(32'h0003_0000);
    rx_valid = 1'b0;
    checks++;
    if (mem_din !== 8'h00) begin
      errors++; $display("FAIL rx_empty_pushpop: got %h expected 00", mem_din);
    end
    do_read(32'h0003_0000);
    checks++;
    if (mem_din !== 8'h77) begin
      errors++; $display("FAIL rx_kept_byte: got %h expected 77", mem_din);
    end
  endtask

  task automatic test_clock();
    logic [31:0] exp_cnt;
    rst_in = 1'b1; step(); rst_in = 1'b0;
    repeat (100) step();
    do_read(32'h0003_0004);
    exp_q.push_back(8'h64); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_b = exp_q.pop_front();
    checks++;
    if (mem_din !== exp_b) begin
      errors++; $display("FAIL clk_lo: got %h expected %h", mem_din, exp_b);
    end
    for (int i = 5; i < 8; i++) begin
      do_read(32'h0003_0000 + 32'(i));
      exp_b = exp_q.pop_front();
      checks++;
      if (mem_din !== exp_b) begin
        errors++; $display("FAIL clk_snap%0d: got %h expected %h", i, mem_din, exp_b);
      end
    end
    exp_cnt = 32'd104;
    do_read(32'h0003_0004);
    checks++;
    if (mem_din !== exp_cnt[7:0]) begin
      errors++; $display("FAIL clk_second: got %h expected %h", mem_din, exp_cnt[7:0]);
    end
    do_read(32'h0003_0001);
    checks++;
    if (mem_din !== 8'h00) begin
      errors++; $display("FAIL io_other: got %h expected 00", mem_din);
    end
  endtask

  task automatic test_finish();
    tx_ready = 1'b0;
    do_write(32'h0000_0300, 8'h12);
    do_write(32'h0003_0004, 8'h55);
    checks++;
    if (program_finished !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL pf_set: got pf %b tv %b td %h expected 1 1 00", program_finished, tx_valid, tx_data);
    end
    repeat (3) step();
    checks++;
    if (program_finished !== 1'b1) begin
      errors++; $display("FAIL pf_sticky: got %b expected 1", program_finished);
    end
    do_write(32'h0003_0000, 8'h41);
    // Reset with TX non-empty and a RAM write in the same cycle.
    rst_in = 1'b1; mem_a = 32'h0000_0300; mem_wr = 1'b1; mem_dout = 8'hEE;
    step();
    rst_in = 1'b0; mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
    checks++;
    if (tx_valid !== 1'b0 || program_finished !== 1'b0 || tx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got tv %b pf %b ov %b expected 0 0 0", tx_valid, program_finished, tx_overflow);
    end
    do_read(32'h0000_0300);
    checks++;
    if (mem_din !== 8'h12) begin
      errors++; $display("FAIL rst_write_blocked: got %h expected 12", mem_din);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b = 8'(i + 1);
      do_write(32'h0003_0000, b);
      tx_q.push_back(b);
    end
    // Push and pop together on a full FIFO: head leaves, new byte enters.
    tx_ready = 1'b1;
    exp_b = tx_q.pop_front();
    checks++;
    if (tx_data !== exp_b) begin
      errors++; $display("FAIL b2b_head: got %h expected %h", tx_data, exp_b);
    end
    do_write(32'h0003_0000, 8'hC7);
    tx_q.push_back(8'hC7);
    tx_ready = 1'b0;
    checks++;
    if (tx_overflow !== 1'b0 || io_buffer_full !== 1'b1) begin
      errors++;
      $display("FAIL b2b_full: got ov %b bf %b expected 0 1", tx_overflow, io_buffer_full);
    end
    drain_tx("b2b");
  endtask

  initial begin
    test_reset();
    test_ram();
    test_tx();
    test_full();
    test_rx();
    test_clock();
    test_finish();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
